// File: rtl/eq_sweep_pkg.sv
// Shared encodings and golden-model helpers for the pair-equality sweep engine.
package eq_sweep_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef logic [1:0] state_t;

  // Widest operand the golden function accepts; callers zero-extend.
  localparam int OPND_MAX_W = 16;

  function automatic int n_vec(input int width);
    return 1 << (2 * width);
  endfunction

  function automatic logic exp_eq(input logic [OPND_MAX_W-1:0] a,
                                  input logic [OPND_MAX_W-1:0] b);
    return a == b;
  endfunction

endpackage

// File: rtl/eq_sweep_ref.sv
// Golden model for the sweep: decodes cnt into {x,y} and flags a wrong eq_in.
module eq_sweep_ref #(
  parameter int WIDTH = 2
) (
  input  logic [2*WIDTH-1:0] cnt,
  input  logic               eq_in,
  output logic               mismatch
);
  import eq_sweep_pkg::*;

  logic [OPND_MAX_W-1:0] xo, yo;
  logic                  expected;

  assign xo       = OPND_MAX_W'(cnt[2*WIDTH-1:WIDTH]);
  assign yo       = OPND_MAX_W'(cnt[WIDTH-1:0]);
  assign expected = exp_eq(xo, yo);
  assign mismatch = (eq_in != expected);

endmodule

// File: rtl/eq_sweep_driver.sv
// Exhaustive sweep initiator: walks every {x,y}, waits RESP_LAT cycles per
// vector, checks eq_in and records mismatch count plus the first bad vector.
module eq_sweep_driver #(
  parameter int WIDTH    = 2,
  parameter int RESP_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [WIDTH-1:0]   x,
  output logic [WIDTH-1:0]   y,
  output logic               vec_valid,
  input  logic               eq_in,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH:0]   err_count,
  output logic [2*WIDTH-1:0] first_err_vec,
  output logic               first_err_valid
);
  import eq_sweep_pkg::*;

  localparam int CNT_W = 2 * WIDTH;
  localparam int N_VEC = n_vec(WIDTH);
  localparam int LAT_W = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_VEC - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RESP_LAT - 1);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [LAT_W-1:0]  lat;
  logic              mismatch;

  eq_sweep_ref #(.WIDTH(WIDTH)) u_ref (
    .cnt      (cnt),
    .eq_in    (eq_in),
    .mismatch (mismatch)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (start) state_nx = ST_DRIVE;
      ST_DRIVE: if (lat == LAT_LAST) state_nx = ST_CHECK;
      ST_CHECK: state_nx = (cnt == CNT_LAST) ? ST_DONE : ST_DRIVE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Operands are forced to zero outside a sweep so an idle bus is quiet.
  assign busy      = (state == ST_DRIVE) || (state == ST_CHECK);
  assign vec_valid = busy;
  assign done      = (state == ST_DONE);
  assign x         = busy ? cnt[CNT_W-1:WIDTH] : '0;
  assign y         = busy ? cnt[WIDTH-1:0]     : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      lat             <= '0;
      err_count       <= '0;
      first_err_vec   <= '0;
      first_err_valid <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (state)
        ST_IDLE: if (start) begin
          cnt             <= '0;
          lat             <= '0;
          err_count       <= '0;
          first_err_vec   <= '0;
          first_err_valid <= 1'b0;
        end
        ST_DRIVE: lat <= (lat == LAT_LAST) ? '0 : lat + 1'b1;
        ST_CHECK: begin
          if (mismatch) begin
            err_count <= err_count + 1'b1;
            if (!first_err_valid) begin
              first_err_vec   <= cnt;
              first_err_valid <= 1'b1;
            end
          end
          // cnt parks on the last vector rather than wrapping.
          if (cnt != CNT_LAST) cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_eq_sweep_driver.sv
// Directed bench: two sweep engines (RESP_LAT 1 and 3) against small comparator models.
module tb_eq_sweep_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, sel;
  int   mode;
  int   total = 0;
  int   bad   = 0;

  logic [1:0] x1, y1, x3, y3;
  logic       vv1, busy1, done1, fv1, eq1;
  logic       vv3, busy3, done3, fv3, eq3;
  logic [4:0] err1, err3;
  logic [3:0] fev1, fev3;
  logic       start1, start3;

  logic [2:0] pipe1 = '0;
  logic [2:0] pipe3 = '0;

  assign start1 = start & ~sel;
  assign start3 = start & sel;

  eq_sweep_driver #(.WIDTH(2), .RESP_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start1), .x(x1), .y(y1), .vec_valid(vv1),
    .eq_in(eq1), .busy(busy1), .done(done1), .err_count(err1),
    .first_err_vec(fev1), .first_err_valid(fv1)
  );

  eq_sweep_driver #(.WIDTH(2), .RESP_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .x(x3), .y(y3), .vec_valid(vv3),
    .eq_in(eq3), .busy(busy3), .done(done3), .err_count(err3),
    .first_err_vec(fev3), .first_err_valid(fv3)
  );

  // 3-stage pipelined ideal comparators
  always @(posedge clk) begin
    pipe1 <= {pipe1[1:0], x1 == y1};
    pipe3 <= {pipe3[1:0], x3 == y3};
  end
  assign eq3 = pipe3[2];

  always_comb begin
    eq1 = 1'b0;
    case (mode)
      0: eq1 = (x1 == y1);
      1: eq1 = 1'b0;
      2: eq1 = 1'b1;
      3: eq1 = (x1 == y1) || (x1 == 2'd2 && y1 == 2'd3);
      4: eq1 = pipe1[2];
      default: eq1 = 1'b0;
    endcase
  end

  logic [1:0] cur_x, cur_y;
  logic       cur_busy, cur_done, cur_vv;
  assign cur_x    = sel ? x3 : x1;
  assign cur_y    = sel ? y3 : y1;
  assign cur_busy = sel ? busy3 : busy1;
  assign cur_done = sel ? done3 : done1;
  assign cur_vv   = sel ? vv3 : vv1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulse start, then track busy length, done pulses and the x/y walk.
  task automatic sweep(input int lat, input bit restart10,
                       output int nb, output int nd, output int se);
    int k;
    bit prev_busy, seen;
    nb = 0; nd = 0; se = 0; prev_busy = 0; seen = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (cur_busy) begin
        k = nb / (lat + 1);
        if (cur_x !== 2'(k >> 2) || cur_y !== 2'(k & 3) || !cur_vv) se++;
        nb++;
      end else if (cur_x != 0 || cur_y != 0 || cur_vv) se++;
      if (cur_done) begin
        nd++;
        if (!prev_busy) se++;
      end
      if (nb > 0 && !cur_busy && !cur_done) begin
        seen = 1;
        break;
      end
      prev_busy = cur_busy;
      start = restart10 && (nb == 10);
      @(negedge clk);
    end
    start = 1'b0;
    if (!seen) chk("sweep_timeout", 0, 1);
  endtask

  int nb, nd, se;
  bit hit;

  initial begin
    rst = 1'b1; start = 1'b0; sel = 1'b0; mode = 0;
    repeat (2) @(negedge clk);
    chk("rst_xy_vv", {x1, y1, vv1}, 0);
    chk("rst_busy_done", {busy1, done1}, 0);
    chk("rst_results", {err1, fev1, fv1}, 0);
    rst = 1'b0;
    @(negedge clk);

    // ideal comparator
    mode = 0;
    sweep(1, 0, nb, nd, se);
    chk("ideal_busy", nb, 32);
    chk("ideal_done", nd, 1);
    chk("ideal_seq", se, 0);
    chk("ideal_err", err1, 0);
    chk("ideal_fv", fv1, 0);

    mode = 1;
    sweep(1, 0, nb, nd, se);
    chk("st0_err", err1, 4);
    chk("st0_fev", fev1, 4'b0000);
    chk("st0_fv", fv1, 1);

    mode = 2;
    sweep(1, 0, nb, nd, se);
    chk("st1_err", err1, 12);
    chk("st1_fev", fev1, 4'b0001);
    chk("st1_fv", fv1, 1);

    // single fault plus ignored mid-sweep start
    mode = 3;
    sweep(1, 1, nb, nd, se);
    chk("flt_busy", nb, 32);
    chk("flt_done", nd, 1);
    chk("flt_seq", se, 0);
    chk("flt_err", err1, 1);
    chk("flt_fev", fev1, 4'b1011);
    repeat (3) @(negedge clk);
    chk("flt_no_restart", {busy1, err1}, {1'b0, 5'd1});

    // latency-matched pipelined comparator
    sel = 1'b1;
    sweep(3, 0, nb, nd, se);
    chk("lat3_busy", nb, 64);
    chk("lat3_seq", se, 0);
    chk("lat3_err", err3, 0);
    chk("lat3_fv", fv3, 0);
    sel = 1'b0;

    // latency mismatch: each check sees the previous vector's answer
    mode = 4;
    sweep(1, 0, nb, nd, se);
    chk("lat1pipe_err", err1, 6);
    chk("lat1pipe_fev", fev1, 4'b0001);

    // reset mid-sweep at cnt=5 with results already dirty
    mode = 1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    hit = 0;
    for (int i = 0; i < 100; i++) begin
      if (busy1 && x1 == 2'd1 && y1 == 2'd1) begin
        hit = 1;
        break;
      end
      @(negedge clk);
    end
    chk("mid_reached_cnt5", hit, 1);
    chk("mid_dirty_err", err1, 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_outs", {x1, y1, vv1, busy1, done1}, 0);
    chk("mid_rst_results", {err1, fev1, fv1}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_idle", {busy1, done1}, 0);

    mode = 0;
    sweep(1, 0, nb, nd, se);
    chk("post_busy", nb, 32);
    chk("post_seq", se, 0);
    chk("post_err", err1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
